// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus scheduler: states, requester ids,
// default phase timings and the arbitration priority order.
package rtc_bus_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned DW      = 8;
  localparam int unsigned CW      = 8;

  localparam int unsigned REQ_INIT  = 0;
  localparam int unsigned REQ_READ  = 1;
  localparam int unsigned REQ_WRITE = 2;

  localparam int unsigned DEF_T_SETUP  = 4;
  localparam int unsigned DEF_T_STROBE = 10;
  localparam int unsigned DEF_T_HOLD   = 4;
  localparam int unsigned DEF_T_GAP    = 8;

  // Highest priority first: init, then write, then read.
  localparam int unsigned PRIO_ORDER [NUM_REQ] = '{REQ_INIT, REQ_WRITE, REQ_READ};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_SETUP,
    ST_ADDR_STB,
    ST_ADDR_HOLD,
    ST_DATA_SETUP,
    ST_DATA_STB,
    ST_DATA_HOLD,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic          rnw;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  function automatic logic [1:0] pick_winner(input logic [NUM_REQ-1:0] req);
    logic [1:0] win;
    if (req[PRIO_ORDER[0]])      win = 2'(PRIO_ORDER[0]);
    else if (req[PRIO_ORDER[1]]) win = 2'(PRIO_ORDER[1]);
    else                         win = 2'(PRIO_ORDER[2]);
    return win;
  endfunction

  function automatic txn_t pick_txn(input logic [1:0]            idx,
                                    input logic [NUM_REQ-1:0]    rnw,
                                    input logic [NUM_REQ*DW-1:0] addr,
                                    input logic [NUM_REQ*DW-1:0] wdata);
    txn_t t;
    t.rnw   = rnw[idx];
    t.addr  = addr[{idx, 3'b000} +: DW];
    t.wdata = wdata[{idx, 3'b000} +: DW];
    return t;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase duration down-counter: loaded with (T-1) on phase entry, stops at zero.
module rtc_phase_timer
  import rtc_bus_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expire_c,
  output logic          expire_next_c
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expire_c = (cnt_q == '0);
  // Lets the owner register a flag that lines up with the final phase cycle.
  assign expire_next_c = load ? (load_val == '0) : (cnt_q <= CW'(1));

endmodule

// File: rtl/rtc_bus_sched.sv
// Fixed-priority scheduler that turns single-byte requests into two-phase
// (address, then data) cycles on the multiplexed RTC bus.
module rtc_bus_sched
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SETUP  = DEF_T_SETUP,
  parameter int unsigned T_STROBE = DEF_T_STROBE,
  parameter int unsigned T_HOLD   = DEF_T_HOLD,
  parameter int unsigned T_GAP    = DEF_T_GAP
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_rnw,
  input  logic [NUM_REQ*DW-1:0]   req_addr,
  input  logic [NUM_REQ*DW-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic [DW-1:0]           rdata,
  output logic                    busy,
  output logic                    a_d,
  output logic                    cs,
  output logic                    rd,
  output logic                    wr,
  output logic [DW-1:0]           bus_out,
  output logic                    bus_oe,
  input  logic [DW-1:0]           bus_in
);

  localparam logic [CW-1:0] LD_SETUP  = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_STROBE = CW'(T_STROBE - 1);
  localparam logic [CW-1:0] LD_HOLD   = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_GAP    = CW'(T_GAP - 1);

  state_e              state_q, state_d;
  logic [1:0]          win_q, win_d;
  txn_t                txn_q, txn_d;
  logic                load;
  logic [CW-1:0]       load_val;
  logic                expire_c, expire_next_c;

  logic [NUM_REQ-1:0]  grant_d, done_d;
  logic [DW-1:0]       rdata_d, bus_out_d;
  logic                busy_d, a_d_d, cs_d, rd_d, wr_d, bus_oe_d;
  logic                in_addr, in_data, drive_data;

  rtc_phase_timer u_timer (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .load_val      (load_val),
    .expire_c      (expire_c),
    .expire_next_c (expire_next_c)
  );

  // Next state, phase timer loads, and next values of all registered outputs.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    txn_d    = txn_q;
    load     = 1'b0;
    load_val = '0;
    rdata_d  = rdata;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          win_d    = pick_winner(req);
          txn_d    = pick_txn(win_d, req_rnw, req_addr, req_wdata);
          state_d  = ST_ADDR_SETUP;
          load     = 1'b1;
          load_val = LD_SETUP;
        end
      end
      ST_ADDR_SETUP: if (expire_c) begin state_d = ST_ADDR_STB;   load = 1'b1; load_val = LD_STROBE; end
      ST_ADDR_STB:   if (expire_c) begin state_d = ST_ADDR_HOLD;  load = 1'b1; load_val = LD_HOLD;   end
      ST_ADDR_HOLD:  if (expire_c) begin state_d = ST_DATA_SETUP; load = 1'b1; load_val = LD_SETUP;  end
      ST_DATA_SETUP: if (expire_c) begin state_d = ST_DATA_STB;   load = 1'b1; load_val = LD_STROBE; end
      ST_DATA_STB: begin
        if (expire_c) begin
          state_d  = ST_DATA_HOLD;
          load     = 1'b1;
          load_val = LD_HOLD;
          if (txn_q.rnw) rdata_d = bus_in;
        end
      end
      ST_DATA_HOLD:  if (expire_c) begin state_d = ST_GAP;        load = 1'b1; load_val = LD_GAP;    end
      ST_GAP:        if (expire_c) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase

    in_addr    = (state_d == ST_ADDR_SETUP) || (state_d == ST_ADDR_STB) || (state_d == ST_ADDR_HOLD);
    in_data    = (state_d == ST_DATA_SETUP) || (state_d == ST_DATA_STB) || (state_d == ST_DATA_HOLD);
    drive_data = in_data && !txn_d.rnw;

    busy_d    = (state_d != ST_IDLE);
    grant_d   = busy_d ? onehot(win_d) : '0;
    // done coincides with the final GAP cycle; grant falls with it on the next edge.
    done_d    = ((state_d == ST_GAP) && expire_next_c) ? onehot(win_d) : '0;
    a_d_d     = in_data;
    cs_d      = !((state_d == ST_ADDR_STB) || (state_d == ST_DATA_STB));
    wr_d      = !((state_d == ST_ADDR_STB) || ((state_d == ST_DATA_STB) && !txn_d.rnw));
    rd_d      = !((state_d == ST_DATA_STB) && txn_d.rnw);
    bus_oe_d  = in_addr || drive_data;
    bus_out_d = in_addr ? txn_d.addr : (drive_data ? txn_d.wdata : '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      txn_q   <= '0;
      grant   <= '0;
      done    <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      a_d     <= 1'b0;
      cs      <= 1'b1;
      rd      <= 1'b1;
      wr      <= 1'b1;
      bus_out <= '0;
      bus_oe  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      txn_q   <= txn_d;
      grant   <= grant_d;
      done    <= done_d;
      rdata   <= rdata_d;
      busy    <= busy_d;
      a_d     <= a_d_d;
      cs      <= cs_d;
      rd      <= rd_d;
      wr      <= wr_d;
      bus_out <= bus_out_d;
      bus_oe  <= bus_oe_d;
    end
  end

endmodule

// File: tb/tb_rtc_bus_sched.sv
// Bench for rtc_bus_sched: table vectors, hand sequences and random traffic
// checked cycle by cycle against a phase-schedule model.
module tb_rtc_bus_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  req_rnw = '0;
  logic [23:0] req_addr = '0;
  logic [23:0] req_wdata = '0;
  logic [7:0]  bus_in = '0;

  logic [2:0] grant_m, done_m, grant_f, done_f;
  logic [7:0] rdata_m, bus_out_m, rdata_f, bus_out_f;
  logic       busy_m, a_d_m, cs_m, rd_m, wr_m, bus_oe_m;
  logic       busy_f, a_d_f, cs_f, rd_f, wr_f, bus_oe_f;

  int checks = 0;
  int errors = 0;
  logic [7:0] mrd [2];

  always #5 clk = ~clk;

  rtc_bus_sched dut (
    .clk(clk), .reset(reset), .req(req), .req_rnw(req_rnw), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant_m), .done(done_m), .rdata(rdata_m), .busy(busy_m),
    .a_d(a_d_m), .cs(cs_m), .rd(rd_m), .wr(wr_m), .bus_out(bus_out_m), .bus_oe(bus_oe_m),
    .bus_in(bus_in)
  );

  rtc_bus_sched #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1), .T_GAP(1)) dut_fast (
    .clk(clk), .reset(reset), .req(req), .req_rnw(req_rnw), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant_f), .done(done_f), .rdata(rdata_f), .busy(busy_f),
    .a_d(a_d_f), .cs(cs_f), .rd(rd_f), .wr(wr_f), .bus_out(bus_out_f), .bus_oe(bus_oe_f),
    .bus_in(bus_in)
  );

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  rnw;
    logic [23:0] addr;
    logic [23:0] wdata;
    logic [7:0]  bus_in;
    logic [2:0]  exp_grant;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t tv [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {grant, done, busy, a_d, cs, rd, wr, bus_oe, bus_out}
  function automatic logic [19:0] act_vec(input int sel);
    if (sel == 0) return {grant_m, done_m, busy_m, a_d_m, cs_m, rd_m, wr_m, bus_oe_m, bus_out_m};
    return {grant_f, done_f, busy_f, a_d_f, cs_f, rd_f, wr_f, bus_oe_f, bus_out_f};
  endfunction

  function automatic logic [7:0] act_rdata(input int sel);
    return (sel == 0) ? rdata_m : rdata_f;
  endfunction

  function automatic int dur(input int sel, input int p);
    int s, b, h, g;
    if (sel == 0) begin s = 4; b = 10; h = 4; g = 8; end
    else          begin s = 1; b = 1;  h = 1; g = 1; end
    case (p)
      0, 3:    return s;
      1, 4:    return b;
      2, 5:    return h;
      default: return g;
    endcase
  endfunction

  function automatic int txn_len(input int sel);
    int n = 0;
    for (int p = 0; p < 7; p++) n += dur(sel, p);
    return n;
  endfunction

  function automatic logic [1:0] model_winner(input logic [2:0] r);
    if (r[0]) return 2'd0;
    if (r[2]) return 2'd2;
    return 2'd1;
  endfunction

  // Expected bus outputs k cycles after the first address-setup cycle.
  function automatic logic [19:0] exp_vec(input int sel, input int k, input logic [1:0] who,
                                          input logic rnw, input logic [7:0] a, input logic [7:0] w);
    int p, acc;
    logic ad, c, r, wrn, oe;
    logic [7:0] bo;
    logic [2:0] g, d;
    p = 0; acc = dur(sel, 0);
    while (k >= acc) begin p++; acc += dur(sel, p); end
    ad = 1'b0; c = 1'b1; r = 1'b1; wrn = 1'b1; oe = 1'b0; bo = '0;
    if (p <= 2) begin
      oe = 1'b1; bo = a;
      if (p == 1) begin c = 1'b0; wrn = 1'b0; end
    end else if (p <= 5) begin
      ad = 1'b1;
      if (!rnw) begin oe = 1'b1; bo = w; end
      if (p == 4) begin c = 1'b0; if (rnw) r = 1'b0; else wrn = 1'b0; end
    end
    g = 3'b001 << who;
    d = (k == txn_len(sel) - 1) ? g : 3'b000;
    return {g, d, 1'b1, ad, c, r, wrn, oe, bo};
  endfunction

  localparam logic [19:0] IDLE_VEC = {3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

  function automatic logic [19:0] masked(input logic [19:0] act, input logic [19:0] exp);
    logic [19:0] v;
    v = act;
    if (!exp[8]) v[7:0] = '0;
    return v;
  endfunction

  // One transaction from the grant edge to the done cycle; DUT must be idle on entry.
  task automatic serve(input int sel, input bit mutate, input logic [2:0] inj, output logic [2:0] fg);
    logic [1:0] who, r;
    logic rnw;
    logic [7:0] a, w, new_rd;
    logic [19:0] e;
    int L;
    who = model_winner(req);
    rnw = req_rnw[who];
    a = req_addr[{who, 3'b000} +: 8];
    w = req_wdata[{who, 3'b000} +: 8];
    new_rd = rnw ? bus_in : mrd[sel];
    L = txn_len(sel);
    fg = '0;
    for (int k = 0; k < L; k++) begin
      @(posedge clk); #1;
      e = exp_vec(sel, k, who, rnw, a, w);
      chk($sformatf("cyc%0d_sel%0d_req%0d", k, sel, who), masked(act_vec(sel), e), e);
      if (k == 0) fg = act_vec(sel)[19:17];
      if (k == L - 1) chk("done_rdata", act_rdata(sel), new_rd);
      if (k == 10) req = req | inj;
      if (mutate) begin
        if (k == 1) begin
          req_addr[{who, 3'b000} +: 8]  = ~a;
          req_wdata[{who, 3'b000} +: 8] = ~w;
          req_rnw[who] = ~rnw;
        end
        if (k == 3 && $urandom_range(0, 1) == 1) begin
          r = 2'($urandom_range(0, 2));
          req[r] = 1'b1;
        end
        if (k == 5 && $urandom_range(0, 3) == 0) req[who] = 1'b0;
      end
    end
    mrd[sel] = new_rd;
    req[who] = 1'b0;
  endtask

  task automatic idle_check(input int sel);
    @(posedge clk); #1;
    chk("idle", masked(act_vec(sel), IDLE_VEC), IDLE_VEC);
    chk("idle_rdata", act_rdata(sel), mrd[sel]);
  endtask

  task automatic serve_all(input int sel, input bit mutate);
    logic [2:0] fg;
    int n = 0;
    while (req != 3'b000 && n < 12) begin
      serve(sel, mutate, 3'b000, fg);
      idle_check(sel);
      n++;
    end
    if (n >= 12) chk("serve_all_bound", 32'(req), 32'd0);
  endtask

  initial begin
    logic [2:0] fg;
    mrd[0] = '0; mrd[1] = '0;
    tv[0] = '{3'b100, 3'b000, 24'h21_0000, 24'h59_0000, 8'h00, 3'b100, 8'h00};
    tv[1] = '{3'b010, 3'b010, 24'h00_2200, 24'h00_0000, 8'h37, 3'b010, 8'h37};
    tv[2] = '{3'b110, 3'b010, 24'h33_4400, 24'h55_0000, 8'h5A, 3'b100, 8'h5A};
    tv[3] = '{3'b101, 3'b001, 24'h66_000F, 24'h77_0000, 8'hA5, 3'b001, 8'hA5};
    tv[4] = '{3'b011, 3'b011, 24'h00_1234, 24'h00_0000, 8'hC3, 3'b001, 8'hC3};
    tv[5] = '{3'b100, 3'b000, 24'h7F_0000, 24'hE1_0000, 8'h00, 3'b100, 8'hC3};

    #1 reset = 1'b0;
    #2;
    chk("reset_outputs", masked(act_vec(0), IDLE_VEC), IDLE_VEC);
    chk("reset_rdata", rdata_m, 8'h00);
    @(posedge clk); #1 reset = 1'b1;
    idle_check(0);

    // Table vectors: first grant and final rdata per row, every cycle checked.
    for (int i = 0; i < 6; i++) begin
      req_rnw = tv[i].rnw; req_addr = tv[i].addr; req_wdata = tv[i].wdata;
      bus_in = tv[i].bus_in; req = tv[i].req;
      serve(0, 1'b0, 3'b000, fg);
      chk($sformatf("tv%0d_grant", i), 32'(fg), 32'(tv[i].exp_grant));
      idle_check(0);
      serve_all(0, 1'b0);
      chk($sformatf("tv%0d_rdata", i), 32'(rdata_m), 32'(tv[i].exp_rdata));
    end

    // Init request arriving during a read waits for the next grant.
    req_rnw = 3'b011; req_addr = 24'h00_2208; bus_in = 8'h37; req = 3'b010;
    serve(0, 1'b0, 3'b001, fg);
    chk("inj_read_grant", 32'(fg), 32'h2);
    idle_check(0);
    serve(0, 1'b0, 3'b000, fg);
    chk("inj_init_grant", 32'(fg), 32'h1);
    idle_check(0);

    // Reset in the middle of the address strobe aborts without done.
    req_rnw = 3'b000; req_addr = 24'h4C_0000; req_wdata = 24'h1E_0000; req = 3'b100;
    repeat (8) @(posedge clk);
    #1 chk("rst_pre_wr", 32'(wr_m), 32'd0);
    #3 reset = 1'b0;
    #1 chk("rst_async", masked(act_vec(0), IDLE_VEC), IDLE_VEC);
    chk("rst_async_rdata", rdata_m, 8'h00);
    mrd[0] = '0; mrd[1] = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_hold", masked(act_vec(0), IDLE_VEC), IDLE_VEC);
    end
    reset = 1'b1;
    serve(0, 1'b0, 3'b000, fg);
    chk("rst_reserve_grant", 32'(fg), 32'h4);
    idle_check(0);

    // Random traffic with late arrivals, dropped requests and post-grant input changes.
    for (int i = 0; i < 15; i++) begin
      req_rnw = 3'($urandom); req_addr = 24'($urandom); req_wdata = 24'($urandom);
      bus_in = 8'($urandom); req = 3'($urandom_range(1, 7));
      serve_all(0, 1'b1);
    end

    // Minimum timings: 7-cycle transactions, rdata kept across a write.
    req = 3'b000;
    repeat (60) @(posedge clk);
    #1;
    req_rnw = 3'b010; req_addr = 24'h00_2200; bus_in = 8'h37; req = 3'b010;
    serve(1, 1'b0, 3'b000, fg);
    chk("fast_read_grant", 32'(fg), 32'h2);
    idle_check(1);
    req_rnw = 3'b000; req_addr = 24'h21_0000; req_wdata = 24'h59_0000; bus_in = 8'hC8; req = 3'b100;
    serve(1, 1'b0, 3'b000, fg);
    idle_check(1);
    chk("fast_rdata_kept", 32'(rdata_f), 32'h37);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
